// File: rtl/wam_pkg.sv
// Shared types and constants for the whack-a-mole hit judge: FSM state
// encoding, light count and the "no light" code.
package wam_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_LIGHT = 2'd1,
    OPEN       = 2'd2,
    CLOSED     = 2'd3
  } state_t;

  localparam logic [3:0] NUM_LIGHTS = 4'd9;
  localparam logic [3:0] NO_LIGHT   = 4'hF;

  function automatic logic light_is_valid(input logic [3:0] pos);
    return (pos != NO_LIGHT) && (pos < NUM_LIGHTS);
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: one-cycle pulse when d goes 0->1 relative to the
// registered previous sample. A held-high level yields a single pulse.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic d,
  output logic pulse
);

  logic prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      prev_q <= 1'b0;
    else if (clear) prev_q <= 1'b0;
    else            prev_q <= d;
  end

  assign pulse = d & ~prev_q;

endmodule

// File: rtl/hit_judge.sv
// Judges key presses against a lit position, keeps score and lives.
// Optional macro HIT_JUDGE_TIMEOUT_MISS_EN: an unanswered window counts as a miss.
//
// Handshake: there is no valid/ready pair here; light_change and key_down are
// plain levels whose rising edges are the events. Judgement strobes are
// registered and appear one cycle after the press edge that caused them.
module hit_judge
  import wam_pkg::*;
#(
  parameter int SCORE_W = 6,
  parameter int LIVES_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               arm,
  input  logic               load_lives,
  input  logic [LIVES_W-1:0] lives_init,
  input  logic [3:0]         light_pos,
  input  logic               light_change,
  input  logic [3:0]         key,
  input  logic               key_down,
  output logic [SCORE_W-1:0] score,
  output logic [LIVES_W-1:0] lives_left,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic               out_of_lives,
  output state_t             state_dbg
);

  state_t state_q, state_d;
  logic   light_ev, key_ev, light_ok;
  logic   judge, timeout_miss, hit_now, miss_press;
  logic   loaded_q;
  logic [1:0] miss_cnt;

  rise_detect u_light_edge (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .d     (light_change),
    .pulse (light_ev)
  );

  rise_detect u_key_edge (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .d     (key_down),
    .pulse (key_ev)
  );

  assign light_ok = light_is_valid(light_pos);

  always_comb begin
    state_d      = state_q;
    judge        = 1'b0;
    timeout_miss = 1'b0;
    if (!arm) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = WAIT_LIGHT;
        WAIT_LIGHT: begin
          if (light_ev && light_ok) begin
            judge   = key_ev;
            state_d = key_ev ? CLOSED : OPEN;
          end
        end
        OPEN: begin
          if (light_ev) begin
`ifdef HIT_JUDGE_TIMEOUT_MISS_EN
            timeout_miss = 1'b1;
`endif
            if (light_ok) begin
              judge   = key_ev;
              state_d = key_ev ? CLOSED : OPEN;
            end else begin
              state_d = WAIT_LIGHT;
            end
          end else if (key_ev) begin
            judge   = 1'b1;
            state_d = CLOSED;
          end
        end
        CLOSED: begin
          if (light_ev) begin
            if (light_ok) begin
              judge   = key_ev;
              state_d = key_ev ? CLOSED : OPEN;
            end else begin
              state_d = WAIT_LIGHT;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A coincident press is judged against the light_pos presented with the edge.
  assign hit_now    = judge && (key == light_pos);
  assign miss_press = judge && (key != light_pos);
  assign miss_cnt   = {1'b0, miss_press} + {1'b0, timeout_miss};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      score      <= '0;
      lives_left <= '0;
      loaded_q   <= 1'b0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else if (clear) begin
      state_q    <= IDLE;
      score      <= '0;
      lives_left <= '0;
      loaded_q   <= 1'b0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      state_q <= state_d;
      // When a timeout miss and a press hit coincide, only miss_pulse strobes
      // so the two pulses stay exclusive; score and lives both still update.
      hit_pulse  <= hit_now & ~timeout_miss;
      miss_pulse <= miss_press | timeout_miss;
      if (hit_now && (score != {SCORE_W{1'b1}}))
        score <= score + 1'b1;
      if (load_lives) begin
        lives_left <= lives_init;
        loaded_q   <= 1'b1;
      end else if (miss_cnt != 2'd0) begin
        lives_left <= (lives_left > LIVES_W'(miss_cnt)) ?
                      lives_left - LIVES_W'(miss_cnt) : '0;
      end
    end
  end

  assign out_of_lives = loaded_q && (lives_left == '0);
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_hit_judge.sv
// Directed table-driven bench for hit_judge plus hand-written sequences for
// saturation, held keys, reset mid-window and the unanswered-window option.
module tb_hit_judge;
  import wam_pkg::*;

  localparam int SCORE_W = 6;
  localparam int LIVES_W = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               clear = 1'b0;
  logic               arm = 1'b0;
  logic               load_lives = 1'b0;
  logic [LIVES_W-1:0] lives_init = '0;
  logic [3:0]         light_pos = NO_LIGHT;
  logic               light_change = 1'b0;
  logic [3:0]         key = '0;
  logic               key_down = 1'b0;
  logic [SCORE_W-1:0] score;
  logic [LIVES_W-1:0] lives_left;
  logic               hit_pulse, miss_pulse, out_of_lives;
  state_t             state_dbg;

  int checks = 0;
  int errors = 0;

  hit_judge #(.SCORE_W(SCORE_W), .LIVES_W(LIVES_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .arm          (arm),
    .load_lives   (load_lives),
    .lives_init   (lives_init),
    .light_pos    (light_pos),
    .light_change (light_change),
    .key          (key),
    .key_down     (key_down),
    .score        (score),
    .lives_left   (lives_left),
    .hit_pulse    (hit_pulse),
    .miss_pulse   (miss_pulse),
    .out_of_lives (out_of_lives),
    .state_dbg    (state_dbg)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic       arm;
    logic       ld;
    logic [3:0] li;
    logic [3:0] lp;
    logic       lc;
    logic [3:0] k;
    logic       kd;
    logic [5:0] sc;
    logic [3:0] lv;
    logic       hit;
    logic       miss;
    logic       ool;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs on the falling edge, then step past the next rising edge.
  task automatic drive(input logic a, input logic ld, input logic [3:0] li,
                       input logic [3:0] lp, input logic lc,
                       input logic [3:0] k, input logic kd);
    @(negedge clk);
    arm = a; load_lives = ld; lives_init = li;
    light_pos = lp; light_change = lc; key = k; key_down = kd;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input int sc, input int lv,
                            input int h, input int m, input int o);
    check({tag, " score"}, 32'(score), 32'(sc));
    check({tag, " lives"}, 32'(lives_left), 32'(lv));
    check({tag, " hit"}, 32'(hit_pulse), 32'(h));
    check({tag, " miss"}, 32'(miss_pulse), 32'(m));
    check({tag, " ool"}, 32'(out_of_lives), 32'(o));
  endtask

  initial begin
    int hits;
    int exp_lv;
    int exp_miss;

    //            arm ld li    lp    lc k     kd  sc lv   h m o
    tbl[0]  = '{1'b1,1'b1,4'd3,4'hF,1'b0,4'd0,1'b0,6'd0,4'd3,1'b0,1'b0,1'b0};
    tbl[1]  = '{1'b1,1'b0,4'd0,4'd4,1'b1,4'd0,1'b0,6'd0,4'd3,1'b0,1'b0,1'b0};
    tbl[2]  = '{1'b1,1'b0,4'd0,4'd4,1'b1,4'd4,1'b1,6'd1,4'd3,1'b1,1'b0,1'b0};
    tbl[3]  = '{1'b1,1'b0,4'd0,4'd4,1'b1,4'd4,1'b1,6'd1,4'd3,1'b0,1'b0,1'b0};
    tbl[4]  = '{1'b1,1'b0,4'd0,4'd4,1'b0,4'd0,1'b0,6'd1,4'd3,1'b0,1'b0,1'b0};
    tbl[5]  = '{1'b1,1'b0,4'd0,4'd2,1'b1,4'd0,1'b0,6'd1,4'd3,1'b0,1'b0,1'b0};
    tbl[6]  = '{1'b1,1'b0,4'd0,4'd2,1'b1,4'd7,1'b1,6'd1,4'd2,1'b0,1'b1,1'b0};
    tbl[7]  = '{1'b1,1'b0,4'd0,4'd2,1'b1,4'd2,1'b0,6'd1,4'd2,1'b0,1'b0,1'b0};
    tbl[8]  = '{1'b1,1'b0,4'd0,4'd2,1'b1,4'd2,1'b1,6'd1,4'd2,1'b0,1'b0,1'b0};
    tbl[9]  = '{1'b1,1'b0,4'd0,4'd2,1'b0,4'd0,1'b0,6'd1,4'd2,1'b0,1'b0,1'b0};
    tbl[10] = '{1'b1,1'b0,4'd0,4'd5,1'b1,4'd5,1'b1,6'd2,4'd2,1'b1,1'b0,1'b0};
    tbl[11] = '{1'b1,1'b0,4'd0,4'd5,1'b0,4'd0,1'b0,6'd2,4'd2,1'b0,1'b0,1'b0};
    tbl[12] = '{1'b1,1'b0,4'd0,4'd9,1'b1,4'd0,1'b0,6'd2,4'd2,1'b0,1'b0,1'b0};
    tbl[13] = '{1'b1,1'b0,4'd0,4'd9,1'b0,4'd3,1'b1,6'd2,4'd2,1'b0,1'b0,1'b0};
    tbl[14] = '{1'b1,1'b0,4'd0,4'd3,1'b1,4'd3,1'b0,6'd2,4'd2,1'b0,1'b0,1'b0};
    tbl[15] = '{1'b1,1'b0,4'd0,4'd3,1'b1,4'd0,1'b1,6'd2,4'd1,1'b0,1'b1,1'b0};
    tbl[16] = '{1'b1,1'b0,4'd0,4'd3,1'b0,4'd0,1'b0,6'd2,4'd1,1'b0,1'b0,1'b0};
    tbl[17] = '{1'b1,1'b0,4'd0,4'd1,1'b1,4'd0,1'b0,6'd2,4'd1,1'b0,1'b0,1'b0};
    tbl[18] = '{1'b1,1'b1,4'd5,4'd1,1'b1,4'd0,1'b1,6'd2,4'd5,1'b0,1'b1,1'b0};
    tbl[19] = '{1'b1,1'b0,4'd0,4'd1,1'b0,4'd0,1'b0,6'd2,4'd5,1'b0,1'b0,1'b0};
    tbl[20] = '{1'b0,1'b0,4'd0,4'd1,1'b0,4'd0,1'b0,6'd2,4'd5,1'b0,1'b0,1'b0};
    tbl[21] = '{1'b0,1'b0,4'd0,4'd1,1'b1,4'd0,1'b0,6'd2,4'd5,1'b0,1'b0,1'b0};
    tbl[22] = '{1'b0,1'b0,4'd0,4'd1,1'b1,4'd1,1'b1,6'd2,4'd5,1'b0,1'b0,1'b0};

    // Reset block
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].arm, tbl[i].ld, tbl[i].li, tbl[i].lp, tbl[i].lc, tbl[i].k, tbl[i].kd);
      check_outs($sformatf("row%0d", i), int'(tbl[i].sc), int'(tbl[i].lv),
                 int'(tbl[i].hit), int'(tbl[i].miss), int'(tbl[i].ool));
    end

    // Lives run down from 3 with four misses; no wrap below zero.
    drive(1, 1, 4'd3, NO_LIGHT, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 4'd0, 1, 4'd1, 1);
      exp_lv = (3 - i - 1 < 0) ? 0 : 3 - i - 1;
      check($sformatf("under%0d miss", i), 32'(miss_pulse), 32'd1);
      check($sformatf("under%0d lives", i), 32'(lives_left), 32'(exp_lv));
      drive(1, 0, 0, 4'd0, 0, 0, 0);
    end
    check("under ool", 32'(out_of_lives), 32'd1);

    // Synchronous clear
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    check_outs("clear", 0, 0, 0, 0, 0);
    @(negedge clk);
    clear = 1'b0;

    // Score saturation
    drive(1, 0, 0, NO_LIGHT, 0, 0, 0);
    for (int i = 0; i < 63; i++) begin
      drive(1, 0, 0, 4'd0, 1, 4'd0, 1);
      drive(1, 0, 0, 4'd0, 0, 4'd0, 0);
    end
    check("sat score63", 32'(score), 32'd63);
    drive(1, 0, 0, 4'd0, 1, 4'd0, 1);
    check("sat hit", 32'(hit_pulse), 32'd1);
    check("sat score", 32'(score), 32'd63);

    // Key held for ten cycles gives one judgement
    drive(1, 0, 0, 4'd6, 0, 0, 0);
    drive(1, 0, 0, 4'd6, 1, 0, 0);
    drive(1, 0, 0, 4'd6, 0, 0, 0);
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0, 4'd6, 0, 4'd6, 1);
      hits += int'(hit_pulse) + int'(miss_pulse);
    end
    check("held judgements", 32'(hits), 32'd1);
    drive(1, 0, 0, 4'd6, 0, 0, 0);

    // Reset while a window is open
    drive(1, 0, 0, 4'd2, 1, 0, 0);
    reset = 1'b1;
    #1;
    check_outs("rstmid", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(1, 0, 0, 4'd2, 1, 0, 0);
    drive(1, 0, 0, 4'd2, 1, 4'd2, 1);
    check("rstmid press hit", 32'(hit_pulse), 32'd0);
    check("rstmid press miss", 32'(miss_pulse), 32'd0);
    drive(1, 0, 0, 4'd2, 0, 0, 0);
    check("rstmid score", 32'(score), 32'd0);

    // Unanswered window followed by a new light edge
    drive(1, 1, 4'd5, NO_LIGHT, 0, 0, 0);
    drive(1, 0, 0, 4'd3, 1, 0, 0);
    drive(1, 0, 0, 4'd3, 0, 0, 0);
    drive(1, 0, 0, 4'd4, 1, 0, 0);
`ifdef HIT_JUDGE_TIMEOUT_MISS_EN
    exp_miss = 1;
    exp_lv   = 4;
`else
    exp_miss = 0;
    exp_lv   = 5;
`endif
    check("timeout miss", 32'(miss_pulse), 32'(exp_miss));
    check("timeout lives", 32'(lives_left), 32'(exp_lv));
    check("timeout hit", 32'(hit_pulse), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hit_judge.md
HIT_JUDGE -- requirements
Module: hit_judge

Interface
REQ-001 SHALL have parameter SCORE_W, default 6, score/counter width.
REQ-002 SHALL have parameter LIVES_W, default 4, lives counter width.
REQ-003 SHALL have port clk  input  1  system clock (CLOCK_50); one clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port clear  input  1  synchronous restart: same effect as reset, taken at next clk edge.
REQ-006 SHALL have port arm  input  1  level; judging enabled while high (PLAY state).
REQ-007 SHALL have port load_lives  input  1  one-cycle pulse: lives_left <= lives_init.
REQ-008 SHALL have port lives_init  input  LIVES_W  starting lives, 1..9.
REQ-009 SHALL have port light_pos  input  4  lit position 0..8; any other value = no light.
REQ-010 SHALL have port light_change  input  1  level; rising edge opens a new light window.
REQ-011 SHALL have port key  input  4  pressed key code 0..8.
REQ-012 SHALL have port key_down  input  1  level; rising edge = one press event.
REQ-013 SHALL have port score  output  SCORE_W  hit count.
REQ-014 SHALL have port lives_left  output  LIVES_W  remaining lives.
REQ-015 SHALL have port hit_pulse / miss_pulse  output  1 each  one-cycle judgement strobes.
REQ-016 SHALL have port out_of_lives  output  1  high while lives_left == 0 after a load.

Function
REQ-017 Rising edges of light_change and key_down SHALL be detected with registered previous values; levels held high produce exactly one event.
REQ-018 FSM states SHALL be IDLE, WAIT_LIGHT, OPEN, CLOSED.
REQ-019 IDLE -> WAIT_LIGHT when arm=1; any state -> IDLE when arm=0.
REQ-020 WAIT_LIGHT -> OPEN on light edge with light_pos valid; press events in WAIT_LIGHT SHALL be ignored.
REQ-021 OPEN: first press event judged; key==light_pos -> hit, else miss; then -> CLOSED.
REQ-022 CLOSED: further presses ignored; next valid light edge -> OPEN; invalid light edge -> WAIT_LIGHT.
REQ-023 Light edge and press in same cycle: press judged against the new light_pos; new window is consumed (-> CLOSED).
REQ-024 hit_pulse/miss_pulse SHALL assert exactly one cycle after the judged press edge; never both.
REQ-025 Hit: score += 1, saturating at 2^SCORE_W-1 (hit_pulse still asserts).
REQ-026 Miss: lives_left -= 1, saturating at 0; no wrap.
REQ-027 out_of_lives SHALL be combinational from lives_left==0 and a loaded flag set by load_lives.
REQ-028 load_lives takes priority over a same-cycle miss decrement.

Reset
REQ-029 On reset or clear: state=IDLE, score=0, lives_left=0, loaded flag=0, pulses=0, edge-history registers=0.
REQ-030 Reset mid-window SHALL discard the open window; no pulse is emitted for it.

Configuration
REQ-031 Macro HIT_JUDGE_TIMEOUT_MISS_EN: when defined, a light edge while in OPEN (window unanswered) SHALL count as a miss (miss_pulse, lives -1) before opening the new window; if a press coincides, only the press judgement counts for the new window and the timeout miss also applies.
REQ-032 Without the macro, unanswered windows SHALL have no effect.

Structure
REQ-033 Shared package wam_pkg SHALL hold the FSM state typedef, NUM_LIGHTS=9, and NO_LIGHT=4'hF.
REQ-034 One sub-module, rise_detect (clk, reset, clear, d -> pulse), SHALL be instantiated twice.
REQ-035 Implementation SHALL be 120-400 lines RTL, no latches, no derived clocks.

Verification
REQ-036 load_lives with lives_init=3, arm=1, light_pos=4 edge, key=4 press -> hit_pulse once, score=1, lives_left=3.
REQ-037 light_pos=2 window, key=7 press then key=2 press -> one miss_pulse, lives_left 3->2, score unchanged, second press ignored.
REQ-038 Three misses from lives=3 then fourth miss -> lives_left=0, out_of_lives=1, no underflow.
REQ-039 score at 63, hit -> score stays 63, hit_pulse=1; key_down held 10 cycles -> single judgement.
REQ-040 With HIT_JUDGE_TIMEOUT_MISS_EN: two light edges, no press -> one miss_pulse, lives -1; without macro -> no change.
REQ-041 reset asserted mid-OPEN -> all outputs 0 same cycle; subsequent press before new light edge -> no pulse.
